// File: rtl/alu_pkg.sv
// Shared constants for the ALU: default datapath width and function codes.
// Optional build macro ALU_FLAGS_EN is used by alu_if and alu to add z/n flags.
package alu_pkg;

  localparam int ALU_WIDTH = 16;

  localparam logic [3:0] FC_ADD  = 4'b0000;
  localparam logic [3:0] FC_SUB  = 4'b0001;
  localparam logic [3:0] FC_MUL  = 4'b0100;
  localparam logic [3:0] FC_DIV  = 4'b0101;
  localparam logic [3:0] FC_MOV  = 4'b0111;
  localparam logic [3:0] FC_SWAP = 4'b1000;

endpackage

// File: rtl/alu_if.sv
// Operand/result bundle between the datapath (master) and the ALU (slave).
// When ALU_FLAGS_EN is defined, the zero (z) and negative (n) flags are added.
interface alu_if
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
);

  logic        [3:0]       functCode;
  logic signed [WIDTH-1:0] op1;
  logic signed [WIDTH-1:0] op2;
  logic signed [WIDTH-1:0] result;
  logic signed [WIDTH-1:0] remainder;
  logic                    o;
`ifdef ALU_FLAGS_EN
  logic                    z;
  logic                    n;
`endif

`ifdef ALU_FLAGS_EN
  modport master (
    output functCode, op1, op2,
    input  result, remainder, o, z, n
  );

  modport slave (
    input  functCode, op1, op2,
    output result, remainder, o, z, n
  );
`else
  modport master (
    output functCode, op1, op2,
    input  result, remainder, o
  );

  modport slave (
    input  functCode, op1, op2,
    output result, remainder, o
  );
`endif

endinterface

// File: rtl/alu_divider.sv
// Combinational signed divider: truncating quotient, remainder with the
// dividend's sign. Divide-by-zero and most-negative / -1 raise o_exc.
module alu_divider
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic signed [WIDTH-1:0] i_dividend,
  input  logic signed [WIDTH-1:0] i_divisor,
  output logic signed [WIDTH-1:0] o_quotient,
  output logic signed [WIDTH-1:0] o_remainder,
  output logic                    o_exc
);

  localparam logic signed [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic w_div_zero;
  logic w_div_ovf;

  assign w_div_zero = (i_divisor == '0);
  // Only quotient that cannot be represented: most-negative divided by -1.
  assign w_div_ovf  = (i_dividend == MOST_NEG) && (i_divisor == '1);

  // Special cases take priority so the real divider never sees a zero divisor.
  always_comb begin
    o_quotient  = '0;
    o_remainder = '0;
    o_exc       = 1'b0;
    if (w_div_zero) begin
      o_remainder = i_dividend;
      o_exc       = 1'b1;
    end else if (w_div_ovf) begin
      o_quotient  = MOST_NEG;
      o_exc       = 1'b1;
    end else begin
      o_quotient  = i_dividend / i_divisor;
      o_remainder = i_dividend % i_divisor;
    end
  end

endmodule

// File: rtl/alu.sv
// Signed arithmetic/move unit: ADD, SUB, MUL, DIV, MOV, SWAP with registered
// result, remainder (high word / second destination) and overflow flag.
// Asynchronous active-low reset. Optional macro ALU_FLAGS_EN adds z/n outputs.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic  clk,
  input  logic  rst,
  alu_if.slave  bus
);

  logic signed [WIDTH-1:0]   w_sum;
  logic signed [WIDTH-1:0]   w_diff;
  logic signed [2*WIDTH-1:0] w_op1_ext;
  logic signed [2*WIDTH-1:0] w_op2_ext;
  logic signed [2*WIDTH-1:0] w_product;
  logic signed [WIDTH-1:0]   w_quot;
  logic signed [WIDTH-1:0]   w_div_rem;
  logic                      w_div_exc;

  logic signed [WIDTH-1:0]   w_result;
  logic signed [WIDTH-1:0]   w_remainder;
  logic                      w_o;

  logic signed [WIDTH-1:0]   r_result;
  logic signed [WIDTH-1:0]   r_remainder;
  logic                      r_o;

  assign w_sum  = bus.op1 + bus.op2;
  assign w_diff = bus.op1 - bus.op2;

  // Sign-extend before multiplying so the full-width product is exact.
  assign w_op1_ext = {{WIDTH{bus.op1[WIDTH-1]}}, bus.op1};
  assign w_op2_ext = {{WIDTH{bus.op2[WIDTH-1]}}, bus.op2};
  assign w_product = w_op1_ext * w_op2_ext;

  alu_divider #(
    .WIDTH (WIDTH)
  ) u_divider (
    .i_dividend  (bus.op1),
    .i_divisor   (bus.op2),
    .o_quotient  (w_quot),
    .o_remainder (w_div_rem),
    .o_exc       (w_div_exc)
  );

  // Decode the function code into next result/remainder/overflow values.
  always_comb begin
    w_result    = '0;
    w_remainder = '0;
    w_o         = 1'b0;
    case (bus.functCode)
      FC_ADD: begin
        w_result = w_sum;
        w_o      = (bus.op1[WIDTH-1] == bus.op2[WIDTH-1]) &&
                   (w_sum[WIDTH-1] != bus.op1[WIDTH-1]);
      end
      FC_SUB: begin
        w_result = w_diff;
        w_o      = (bus.op1[WIDTH-1] != bus.op2[WIDTH-1]) &&
                   (w_diff[WIDTH-1] != bus.op1[WIDTH-1]);
      end
      FC_MUL: begin
        w_result    = w_product[WIDTH-1:0];
        w_remainder = w_product[2*WIDTH-1:WIDTH];
        // Overflow when the high word is not a pure sign-extension of the low word.
        w_o         = (w_product[2*WIDTH-1:WIDTH] != {WIDTH{w_product[WIDTH-1]}});
      end
      FC_DIV: begin
        w_result    = w_quot;
        w_remainder = w_div_rem;
        w_o         = w_div_exc;
      end
      FC_MOV: begin
        w_result = bus.op1;
      end
      FC_SWAP: begin
        w_result    = bus.op1;
        w_remainder = bus.op2;
      end
      default: begin
        w_result    = '0;
        w_remainder = '0;
        w_o         = 1'b0;
      end
    endcase
  end

  // Output registers: cleared immediately by reset, otherwise load every edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_result    <= '0;
      r_remainder <= '0;
      r_o         <= 1'b0;
    end else begin
      r_result    <= w_result;
      r_remainder <= w_remainder;
      r_o         <= w_o;
    end
  end

  assign bus.result    = r_result;
  assign bus.remainder = r_remainder;
  assign bus.o         = r_o;

`ifdef ALU_FLAGS_EN
  logic r_z;
  logic r_n;

  // Zero/negative flags track the same next-result value as r_result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_z <= 1'b0;
      r_n <= 1'b0;
    end else begin
      r_z <= (w_result == '0);
      r_n <= w_result[WIDTH-1];
    end
  end

  assign bus.z = r_z;
  assign bus.n = r_n;
`endif

endmodule

// File: tb/tb_alu.sv
// Scoreboard testbench for alu: directed vectors push expected responses,
// a monitor pops and compares one edge after each issued operation.
module tb_alu;
  import alu_pkg::*;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic tb_vld = 1'b0;

  alu_if #(.WIDTH(W)) bus();

  alu #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string          name;
    logic [W-1:0]   res;
    logic [W-1:0]   rem;
    logic           o;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic issue(input string name, input logic [3:0] fc,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] er, input logic [W-1:0] erem, input logic eo);
    exp_t e;
    @(negedge clk);
    bus.functCode = fc;
    bus.op1       = a;
    bus.op2       = b;
    tb_vld        = 1'b1;
    e.name = name;
    e.res  = er;
    e.rem  = erem;
    e.o    = eo;
    sb.push_back(e);
  endtask

  // Monitor: one edge after an issued operation, compare against the queue head.
  always @(posedge clk) begin : mon
    exp_t e;
    if (tb_vld && rst) begin
      #1;
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL scoreboard_empty: got output %h with no expected entry", bus.result);
      end else begin
        e = sb.pop_front();
        $display("[TB] %s: result=%h remainder=%h o=%b", e.name, bus.result, bus.remainder, bus.o);
        check({e.name, ".result"}, bus.result, e.res);
        check({e.name, ".remainder"}, bus.remainder, e.rem);
        check({e.name, ".o"}, {15'b0, bus.o}, {15'b0, e.o});
`ifdef ALU_FLAGS_EN
        check({e.name, ".z"}, {15'b0, bus.z}, {15'b0, (e.res == '0)});
        check({e.name, ".n"}, {15'b0, bus.n}, {15'b0, e.res[W-1]});
`endif
      end
    end
  end

  initial begin
    bus.functCode = FC_ADD;
    bus.op1       = '0;
    bus.op2       = '0;
    rst           = 1'b0;
    #3;
    check("reset.result", bus.result, 16'h0000);
    check("reset.remainder", bus.remainder, 16'h0000);
    check("reset.o", {15'b0, bus.o}, 16'h0000);
    @(negedge clk);
    rst = 1'b1;

    // Back-to-back directed vectors, one issued per cycle.
    issue("add_basic",  FC_ADD,  16'h1111, 16'h8888, 16'h9999, 16'h0000, 1'b0);
    issue("add_ovf",    FC_ADD,  16'h7FFF, 16'h0001, 16'h8000, 16'h0000, 1'b1);
    issue("add_negovf", FC_ADD,  16'h8000, 16'h8000, 16'h0000, 16'h0000, 1'b1);
    issue("sub_ovf",    FC_SUB,  16'h8000, 16'h0001, 16'h7FFF, 16'h0000, 1'b1);
    issue("sub_basic",  FC_SUB,  16'h0005, 16'h0003, 16'h0002, 16'h0000, 1'b0);
    issue("sub_zero",   FC_SUB,  16'h0003, 16'h0003, 16'h0000, 16'h0000, 1'b0);
    issue("mul_one",    FC_MUL,  16'h0001, 16'h0001, 16'h0001, 16'h0000, 1'b0);
    issue("mul_ovf",    FC_MUL,  16'h0100, 16'h0100, 16'h0000, 16'h0001, 1'b1);
    issue("mul_neg",    FC_MUL,  16'hFFFF, 16'h0002, 16'hFFFE, 16'hFFFF, 1'b0);
    issue("mul_negneg", FC_MUL,  16'hFFFF, 16'hFFFF, 16'h0001, 16'h0000, 1'b0);
    issue("div_pos",    FC_DIV,  16'h0007, 16'h0002, 16'h0003, 16'h0001, 1'b0);
    issue("div_neg",    FC_DIV,  16'hFFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 1'b0);
    issue("div_zero",   FC_DIV,  16'h0005, 16'h0000, 16'h0000, 16'h0005, 1'b1);
    issue("div_ovf",    FC_DIV,  16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b1);
    issue("mov",        FC_MOV,  16'h1234, 16'h9999, 16'h1234, 16'h0000, 1'b0);
    issue("unused_f",   4'hF,    16'h1234, 16'h5678, 16'h0000, 16'h0000, 1'b0);
    issue("unused_2",   4'h2,    16'h7FFF, 16'h7FFF, 16'h0000, 16'h0000, 1'b0);
    issue("swap",       FC_SWAP, 16'hAAAA, 16'h5555, 16'hAAAA, 16'h5555, 1'b0);
    @(negedge clk);
    tb_vld = 1'b0;

    // Asynchronous reset mid-cycle while outputs hold the SWAP result.
    #2;
    rst = 1'b0;
    #1;
    check("async_reset.result", bus.result, 16'h0000);
    check("async_reset.remainder", bus.remainder, 16'h0000);
    check("async_reset.o", {15'b0, bus.o}, 16'h0000);
    @(negedge clk);
    rst = 1'b1;

    issue("add_after_reset", FC_ADD, 16'h1111, 16'h8888, 16'h9999, 16'h0000, 1'b0);
    @(negedge clk);
    tb_vld = 1'b0;
    repeat (2) @(negedge clk);

    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending entries expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu.md
Name: alu

Overview:
- 16-bit signed arithmetic/move unit of the datapath, selected by a 4-bit function code.
- Computes result, remainder/high-word and a signed-overflow flag.
- All outputs are registered: one clock of latency from operands to outputs.
- Feeds the register-file write-back path, which uses result and, for multiply/divide/swap, remainder.

Parameters:
- WIDTH, 16, operand/result width in bits; all values below assume 16.

Ports:
- clk  input  1  single clock, rising-edge active.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- functCode  input  4  operation select.
- op1  input  WIDTH  signed operand 1.
- op2  input  WIDTH  signed operand 2.
- result  output  WIDTH  signed primary result, registered.
- remainder  output  WIDTH  secondary result, registered.
- o  output  1  overflow/exception flag, registered.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset: while rst=0, result, remainder and o are forced to 0 immediately, independent of clk.
- Operation: on each rising clk with rst=1, the outputs load the combinational function of the current functCode/op1/op2. Latency is 1 cycle, a new operation can be issued every cycle, and there is no handshake.
- Releasing reset: the first capture happens at the first rising edge where rst=1.
- 0000 ADD: result = op1+op2, mod 2^16; remainder = 0. o = 1 iff both operands have the same sign and the result sign differs from it.
- 0001 SUB: result = op1-op2; remainder = 0. o = 1 iff the operands have different signs and the result sign differs from op1's sign.
- 0100 MUL: form the full 32-bit signed product; result = product[15:0], remainder = product[31:16]. o = 1 iff product[31:16] is not the sign-extension of product[15], i.e. the product does not fit in 16 signed bits.
- 0101 DIV: result = op1/op2 truncated toward zero; remainder = op1 % op2, taking the sign of op1; o = 0.
  - Divide by zero (op2=0): result = 0x0000, remainder = op1, o = 1.
  - op1=0x8000 with op2=0xFFFF: result = 0x8000, remainder = 0, o = 1.
- 0111 MOV: result = op1, remainder = 0, o = 0.
- 1000 SWAP: result = op1, remainder = op2, o = 0. Write-back uses remainder as the second destination.
- All other codes: result = 0, remainder = 0, o = 0.
- No X propagation: every output is fully assigned for every code.

Optional Feature:
- Macro ALU_FLAGS_EN.
- When defined, two extra registered 1-bit outputs are present:
  - z: result == 0.
  - n: result[15].
  - Both reset to 0 and follow the same 1-cycle latency as result.
- When undefined, these ports and their logic do not exist; the remaining behaviour is unchanged.

Decomposition:
- Package alu_pkg:
  - WIDTH default.
  - functCode constants: FC_ADD=4'b0000, FC_SUB=4'b0001, FC_MUL=4'b0100, FC_DIV=4'b0101, FC_MOV=4'b0111, FC_SWAP=4'b1000.
- Sub-module alu_divider: combinational signed 16/16 divide. Outputs quotient and remainder, and handles the divide-by-zero and 0x8000/-1 special cases with an exception flag.
- The top level does decode, add/sub/mul and output registers.

Test Plan:
- Reset: assert rst=0 mid-cycle with outputs nonzero -> result, remainder and o go to 0 immediately, without waiting for clk. Release, then ADD 0x1111+0x8888 -> next edge result=0x9999, remainder=0, o=0.
- ADD overflow: 0x7FFF+0x0001 -> result=0x8000, o=1. SUB 0x8000-0x0001 -> result=0x7FFF, o=1. SUB 0x0005-0x0003 -> result=0x0002, o=0.
- MUL 0x0001*0x0001 -> result=0x0001, remainder=0x0000, o=0. MUL 0x0100*0x0100 -> result=0x0000, remainder=0x0001, o=1. MUL 0xFFFF*0x0002 -> result=0xFFFE, remainder=0xFFFF, o=0.
- DIV 7/2 -> result=3, remainder=1. DIV -7/2 -> result=0xFFFD, remainder=0xFFFF. DIV 5/0 -> result=0, remainder=5, o=1. DIV 0x8000/0xFFFF -> result=0x8000, o=1.
- MOV op1=0x1234 -> result=0x1234, remainder=0. SWAP op1=0xAAAA, op2=0x5555 -> result=0xAAAA, remainder=0x5555. Unused code 0x0F -> all outputs 0.
- Back-to-back issue: ADD, MUL, DIV on consecutive cycles -> each result appears exactly one edge after its inputs. With ALU_FLAGS_EN defined: SUB 3-3 -> z=1, n=0.
